// File: rtl/imem_pkg.sv
// Shared constants for the instruction-memory responder and its word array.
package imem_pkg;
  localparam int ADDR_W_DEF     = 16;
  localparam int DATA_W_DEF     = 16;
  localparam int DEPTH_LOG2_DEF = 10;
  localparam int LATENCY_DEF    = 4;
  localparam int CNT_W          = 4;
  localparam logic [15:0] NOP_INSTR = 16'h0800;
endpackage

// File: rtl/imem_array.sv
// Word-addressed instruction store: synchronous write, asynchronous read.
module imem_array #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [DATA_W-1:0]     o_rdata
);

  logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read is combinational, so a write on the read edge is not seen until later.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/imem_responder.sv
// Multi-cycle instruction-memory responder: stall/done handshake toward fetch,
// flush for redirects, and a side preload port into the word store.
module imem_responder
  import imem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int LATENCY    = LATENCY_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic              flush,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] data_out,
  output logic              done,
  output logic              stall,
  output logic              err
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  logic                  r_busy;
  logic [CNT_W-1:0]      r_cnt;
  logic [DEPTH_LOG2-1:0] r_req_idx;
  logic [DATA_W-1:0]     r_data_out;
  logic                  r_done;
  logic                  r_err;

  logic                  w_stall;
  logic                  w_present;
  logic                  w_accept;
  logic                  w_complete;
  logic                  w_unaligned;
  logic [DATA_W-1:0]     w_rdata;
  logic                  w_unused;

  imem_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .i_we    (load_en),
    .i_waddr (load_addr[DEPTH_LOG2:1]),
    .i_wdata (load_data),
    .i_raddr (r_req_idx),
    .o_rdata (w_rdata)
  );

  // Address bits above the store depth wrap; byte-lane bit of preload is ignored.
  assign w_unused = ^{addr[ADDR_W-1:DEPTH_LOG2+1], load_addr[ADDR_W-1:DEPTH_LOG2+1],
                      load_addr[0]};

  assign w_stall     = r_busy & (r_cnt != '0);
  assign w_present   = rd & ~w_stall & ~flush;
  assign w_accept    = w_present & ~addr[0] & ~rst;
  assign w_complete  = r_busy & (r_cnt == '0) & ~flush;
  // A completing response takes priority so done and err never coincide.
  assign w_unaligned = w_present & addr[0] & ~w_complete;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= 1'b0;
      r_cnt      <= '0;
      r_req_idx  <= '0;
      r_data_out <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= w_complete;
      r_err  <= w_unaligned;
      if (w_complete) r_data_out <= w_rdata;
      if (flush) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else if (w_accept) begin
        r_busy    <= 1'b1;
        r_cnt     <= LAT_M1;
        r_req_idx <= addr[DEPTH_LOG2:1];
      end else if (r_busy && (r_cnt == '0)) begin
        r_busy <= 1'b0;
      end else if (r_busy) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign stall    = w_stall;
  assign done     = r_done;
  assign err      = r_err;
  assign data_out = r_data_out;

endmodule

// File: tb/tb_imem_responder.sv
// Randomized and directed scoreboard bench for imem_responder (LATENCY=4).
module tb_imem_responder;

  localparam int L     = 4;
  localparam int NCYC  = 8192;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd = 1'b0;
  logic [15:0] addr = '0;
  logic        flush = 1'b0;
  logic        load_en = 1'b0;
  logic [15:0] load_addr = '0;
  logic [15:0] load_data = '0;
  logic [15:0] data_out;
  logic        done;
  logic        stall;
  logic        err;

  imem_responder #(
    .ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(10), .LATENCY(L)
  ) dut (
    .clk(clk), .rst(rst), .rd(rd), .addr(addr), .flush(flush),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .data_out(data_out), .done(done), .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic [15:0] data;
  } resp_t;

  resp_t       done_q[$];
  int          err_q[$];
  bit          exp_stall [NCYC];
  bit   [15:0] exp_dout  [NCYC];
  logic [15:0] mem [1024];

  // Reference state: the outstanding request, by the cycle it was accepted in.
  bit          p_valid = 0;
  int          p_acc = 0;
  int          p_idx = 0;
  logic [15:0] cur_dout = '0;
  bit          mon_en = 0;

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endfunction

  task automatic step(input logic i_rd, input logic [15:0] i_addr, input logic i_flush,
                      input logic i_le, input logic [15:0] i_la, input logic [15:0] i_ld,
                      input logic i_rst);
    int  c;
    bit  st;
    bit  comp;
    @(posedge clk);
    #1;
    c = cyc;
    rd = i_rd; addr = i_addr; flush = i_flush;
    load_en = i_le; load_addr = i_la; load_data = i_ld; rst = i_rst;
    st = p_valid && (c < p_acc + L);
    if (c < NCYC) exp_stall[c] = st;
    if (i_rst) begin
      p_valid  = 0;
      cur_dout = '0;
    end else if (i_flush) begin
      p_valid = 0;
    end else begin
      comp = p_valid && (c == p_acc + L);
      if (comp) begin
        done_q.push_back('{at: c + 1, data: mem[p_idx]});
        cur_dout = mem[p_idx];
        p_valid  = 0;
      end
      if (i_rd && !st) begin
        if (i_addr[0]) begin
          if (!comp) err_q.push_back(c + 1);
        end else begin
          p_valid = 1;
          p_acc   = c;
          p_idx   = int'(i_addr[10:1]);
        end
      end
    end
    if (i_le) mem[i_la[10:1]] = i_ld;
    if (c + 1 < NCYC) exp_dout[c + 1] = cur_dout;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, '0, 0, 0, '0, '0, 0);
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] d);
    step(0, '0, 0, 1, a, d, 0);
  endtask

  task automatic req(input logic [15:0] a);
    step(1, a, 0, 0, '0, '0, 0);
  endtask

  // Monitor: compares every cycle against the expectations the driver queued.
  always @(negedge clk) begin
    if (mon_en && cyc < NCYC) begin
      resp_t r;
      chk("stall", 32'(stall), 32'(exp_stall[cyc]));
      chk("data_out", 32'(data_out), 32'(exp_dout[cyc]));
      if (done && err) chk("done_err_exclusive", 32'(1), 32'(0));
      while (done_q.size() > 0 && done_q[0].at < cyc) begin
        r = done_q.pop_front();
        chk("done_missing_at", 32'(cyc), 32'(r.at));
      end
      while (err_q.size() > 0 && err_q[0] < cyc) begin
        chk("err_missing_at", 32'(cyc), 32'(err_q.pop_front()));
      end
      if (done) begin
        if (done_q.size() == 0) chk("done_unexpected", 32'(1), 32'(0));
        else begin
          r = done_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(r.at));
          chk("done_data", 32'(data_out), 32'(r.data));
        end
      end
      if (err) begin
        if (err_q.size() == 0) chk("err_unexpected", 32'(1), 32'(0));
        else chk("err_cycle", 32'(cyc), 32'(err_q.pop_front()));
      end
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) step(0, '0, 0, 0, '0, '0, 1);
    mon_en = 1;
    for (int k = 0; k < 1024; k++) load(16'(k * 2), 16'($urandom));

    // Basic read, then the held value afterwards.
    load(16'h0010, 16'h1234);
    req(16'h0010);
    idle(8);
    chk("basic_hold", 32'(data_out), 32'h1234);

    // Back-to-back: next request raised in the final busy cycle.
    load(16'h0002, 16'hAAAA);
    load(16'h0004, 16'hBBBB);
    req(16'h0002);
    for (int k = 0; k < L - 1; k++) req(16'h0002);
    req(16'h0004);
    idle(7);
    chk("b2b_last", 32'(data_out), 32'hBBBB);

    // Unaligned request in idle.
    req(16'h0003);
    idle(4);
    chk("unaligned_keep", 32'(data_out), 32'hBBBB);

    // Flush in cycle 2 of a request, then a fresh request completes.
    load(16'h0012, 16'h4321);
    req(16'h0010);
    idle(1);
    step(0, '0, 1, 0, '0, '0, 0);
    idle(6);
    req(16'h0012);
    idle(6);
    chk("after_flush", 32'(data_out), 32'h4321);

    // Reset mid-request; preload survives.
    req(16'h0010);
    idle(1);
    step(0, '0, 0, 0, '0, '0, 1);
    idle(1);
    chk("rst_dout_zero", 32'(data_out), 32'h0);
    idle(5);
    req(16'h0010);
    idle(6);
    chk("after_rst", 32'(data_out), 32'h1234);

    // Wrap plus a preload racing the in-flight read.
    req(16'h0810);
    idle(1);
    load(16'h0010, 16'h5555);
    idle(6);
    chk("wrap_race", 32'(data_out), 32'h5555);

    // Write in the done cycle itself returns the old word.
    req(16'h0012);
    idle(L - 1);
    load(16'h0012, 16'h9999);
    idle(3);
    chk("done_cycle_write", 32'(data_out), 32'h4321);

    // Unaligned rd in a done cycle loses to the completion.
    req(16'h0010);
    idle(L - 1);
    req(16'h0011);
    idle(4);

    for (int k = 0; k < 1500; k++) begin
      logic        r_rd, r_fl, r_le, r_rs;
      logic [15:0] a, la;
      r_rs = ($urandom_range(0, 99) == 0);
      r_fl = ($urandom_range(0, 99) < 5);
      r_rd = ($urandom_range(0, 99) < 45);
      r_le = !r_rs && ($urandom_range(0, 99) < 25);
      a  = 16'($urandom_range(0, 63)) & 16'hFFFE;
      if ($urandom_range(0, 99) < 15) a[0] = 1'b1;
      if ($urandom_range(0, 9) == 0) a[15:11] = 5'($urandom);
      la = 16'($urandom_range(0, 63));
      step(r_rd, a, r_fl, r_le, la, 16'($urandom), r_rs);
    end
    idle(L + 3);
    chk("done_q_drained", 32'(done_q.size()), 32'(0));
    chk("err_q_drained", 32'(err_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
